// File: rtl/load_store_unit.sv
// RV32 load/store memory stage: req/ack handshake to a 32-bit little-endian data memory.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into error completions.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        error,
  output logic        misaligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_next;
  logic [31:0] r_addr, r_data, cnt, rd_shift, load_ext;
  logic [2:0]  r_f3;
  logic        r_we;
  logic        load_ok, store_ok, illegal, mis, mis_hit, no_op, timeout_hit;
  logic [1:0]  lane;

  always_comb begin
    load_ok  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    store_ok = funct3 inside {3'b000, 3'b001, 3'b010};
    illegal  = (MemRead && MemWrite) || (MemRead && !load_ok) || (MemWrite && !store_ok);
    no_op    = !MemRead && !MemWrite;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = ((funct3[1:0] == 2'b01) && addr[0]) || ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
    mis_hit     = !no_op && !illegal && mis;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TIMEOUT_CYCLES - 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (no_op || illegal || mis_hit) ? RESP : ACCESS;
      ACCESS:  if (mem_ack || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Halfwords use the upper/lower half by addr[1]; words always sit in lane 0.
  always_comb begin
    case (r_f3[1:0])
      2'b00:   lane = r_addr[1:0];
      2'b01:   lane = {r_addr[1], 1'b0};
      default: lane = 2'b00;
    endcase
    rd_shift = mem_rdata >> {lane, 3'b000};
    case (r_f3)
      3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_ext = {24'h0, rd_shift[7:0]};
      3'b101:  load_ext = {16'h0, rd_shift[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == RESP);
    mem_req   = (state == ACCESS);
    mem_we    = mem_req && r_we;
    mem_addr  = mem_req ? {r_addr[31:2], 2'b00} : '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (mem_we) begin
      case (r_f3[1:0])
        2'b00: begin
          mem_be    = 4'b0001 << lane;
          mem_wdata = {4{r_data[7:0]}};
        end
        2'b01: begin
          mem_be    = 4'b0011 << lane;
          mem_wdata = {2{r_data[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = r_data;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_f3       <= '0;
      r_we       <= 1'b0;
      cnt        <= '0;
      load_data  <= '0;
      error      <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (no_op || illegal || mis_hit) begin
            error      <= illegal || mis_hit;
            misaligned <= mis_hit;
          end else begin
            r_addr <= addr;
            r_data <= store_data;
            r_f3   <= funct3;
            r_we   <= MemWrite;
          end
        end
        ACCESS: begin
          cnt <= cnt + 32'd1;
          if (mem_ack) begin
            cnt        <= '0;
            error      <= 1'b0;
            misaligned <= 1'b0;
            if (!r_we) load_data <= load_ext;
          end else if (timeout_hit) begin
            cnt        <= '0;
            error      <= 1'b1;
            misaligned <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
